// File: rtl/apb_usrt_pkg.sv
// Shared types and defaults for the APB-to-USRT bridge.
// The status register sits directly above the last channel data register.
package apb_usrt_pkg;

   typedef enum logic [1:0] {
      s_IDLE   = 2'd0,
      s_SETUP  = 2'd1,
      s_ACCESS = 2'd2,
      s_RESP   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      k_DATA   = 2'd0,
      k_STATUS = 2'd1,
      k_ERROR  = 2'd2
   } kind_t;

   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 32;
   localparam int N_CH_DEF    = 2;
   localparam int TIMEOUT_DEF = 16;

   function automatic int status_index(input int n_ch);
      return n_ch;
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS-state cycles; expire is high in the last cycle allowed
// before the bridge gives up on a channel handshake.
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc)
         count <= count + CW'(1);
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/apb_usrt_slave.sv
// APB slave bridging word registers onto N_CH ready/valid USRT channels,
// with a read-only status word and a bounded wait on each channel handshake.
module apb_usrt_slave
   import apb_usrt_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int N_CH    = N_CH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   i_Pclk,
   input  logic                   i_Preset,
   input  logic                   i_Psel,
   input  logic                   i_Penable,
   input  logic                   i_Pwrite,
   input  logic [ADDR_W-1:0]      i_Paddr,
   input  logic [DATA_W-1:0]      i_Pwdata,
   output logic [DATA_W-1:0]      o_Prdata,
   output logic                   o_Pready,
   output logic                   o_Pslverr,
   output logic [N_CH-1:0]        o_Tx_Valid,
   output logic [DATA_W-1:0]      o_Tx_Data,
   input  logic [N_CH-1:0]        i_Tx_Ready,
   output logic [N_CH-1:0]        o_Rx_Req,
   input  logic [N_CH-1:0]        i_Rx_Valid,
   input  logic [N_CH*DATA_W-1:0] i_Rx_Data
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [ADDR_W-3:0] STATUS_W = (ADDR_W-2)'(status_index(N_CH));

   state_t            state;
   kind_t             kind_dec;
   kind_t             kind_q;
   logic              write_q;
   logic [CH_W-1:0]   ch_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-3:0] w_idx;
   logic [DATA_W-1:0] status_word;
   logic [N_CH-1:0]   ch_onehot;
   logic              handshake;
   logic              timer_clear;
   logic              timer_inc;
   logic              timer_expire;
   logic              unused_addr_lsbs;

   // Byte lanes are not supported, so the low address bits carry no meaning.
   assign unused_addr_lsbs = ^i_Paddr[1:0];
   assign w_idx = i_Paddr[ADDR_W-1:2];

   always_comb begin
      kind_dec = k_ERROR;
      if (w_idx < STATUS_W)
         kind_dec = k_DATA;
      else if ((w_idx == STATUS_W) && !i_Pwrite)
         kind_dec = k_STATUS;
   end

   always_comb begin
      status_word = '0;
      status_word[N_CH-1:0] = i_Tx_Ready;
      status_word[2*N_CH-1:N_CH] = i_Rx_Valid;
   end

   assign ch_onehot   = N_CH'(1) << ch_q;
   assign handshake   = write_q ? i_Tx_Ready[ch_q] : i_Rx_Valid[ch_q];
   assign o_Tx_Data   = wdata_q;
   assign timer_clear = (state == s_SETUP) && i_Psel && i_Penable && (kind_q == k_DATA);
   assign timer_inc   = (state == s_ACCESS);

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk    (i_Pclk),
      .reset  (i_Preset),
      .clear  (timer_clear),
      .inc    (timer_inc),
      .expire (timer_expire)
   );

   always_ff @(posedge i_Pclk) begin
      if (i_Preset) begin
         state      <= s_IDLE;
         kind_q     <= k_DATA;
         write_q    <= 1'b0;
         ch_q       <= '0;
         wdata_q    <= '0;
         o_Prdata   <= '0;
         o_Pready   <= 1'b0;
         o_Pslverr  <= 1'b0;
         o_Tx_Valid <= '0;
         o_Rx_Req   <= '0;
      end else begin
         case (state)
            s_IDLE: begin
               if (i_Psel && !i_Penable) begin
                  kind_q  <= kind_dec;
                  write_q <= i_Pwrite;
                  ch_q    <= w_idx[CH_W-1:0];
                  wdata_q <= i_Pwdata;
                  state   <= s_SETUP;
               end
            end
            s_SETUP: begin
               if (!i_Psel) begin
                  state <= s_IDLE;
               end else if (i_Penable) begin
                  case (kind_q)
                     k_DATA: begin
                        state <= s_ACCESS;
                        if (write_q)
                           o_Tx_Valid <= ch_onehot;
                        else
                           o_Rx_Req <= ch_onehot;
                     end
                     k_STATUS: begin
                        state     <= s_RESP;
                        o_Pready  <= 1'b1;
                        o_Pslverr <= 1'b0;
                        o_Prdata  <= status_word;
                     end
                     default: begin
                        state     <= s_RESP;
                        o_Pready  <= 1'b1;
                        o_Pslverr <= 1'b1;
                        o_Prdata  <= '0;
                     end
                  endcase
               end
            end
            // A handshake landing in the expiry cycle takes priority over the error.
            s_ACCESS: begin
               if (handshake) begin
                  state      <= s_RESP;
                  o_Pready   <= 1'b1;
                  o_Pslverr  <= 1'b0;
                  o_Tx_Valid <= '0;
                  o_Rx_Req   <= '0;
                  if (!write_q)
                     o_Prdata <= i_Rx_Data[int'(ch_q)*DATA_W +: DATA_W];
               end else if (timer_expire) begin
                  state      <= s_RESP;
                  o_Pready   <= 1'b1;
                  o_Pslverr  <= 1'b1;
                  o_Prdata   <= '0;
                  o_Tx_Valid <= '0;
                  o_Rx_Req   <= '0;
               end
            end
            default: begin
               state     <= s_IDLE;
               o_Pready  <= 1'b0;
               o_Pslverr <= 1'b0;
               o_Prdata  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_usrt_slave.sv
// Directed bench for apb_usrt_slave with default parameters (2 channels, TIMEOUT 16).
module tb_apb_usrt_slave;

   logic        i_Pclk;
   logic        i_Preset;
   logic        i_Psel;
   logic        i_Penable;
   logic        i_Pwrite;
   logic [7:0]  i_Paddr;
   logic [31:0] i_Pwdata;
   logic [31:0] o_Prdata;
   logic        o_Pready;
   logic        o_Pslverr;
   logic [1:0]  o_Tx_Valid;
   logic [31:0] o_Tx_Data;
   logic [1:0]  i_Tx_Ready;
   logic [1:0]  o_Rx_Req;
   logic [1:0]  i_Rx_Valid;
   logic [63:0] i_Rx_Data;

   int testCount = 0;
   int failCount = 0;
   int cycle = 0;

   int          lastLatency;
   int          lastReadyCycle;
   logic [31:0] lastRdata;
   logic        lastSlverr;
   logic [1:0]  txSeen;
   int          txCycles;
   logic [31:0] txDataSeen;
   logic [1:0]  rxSeen;
   logic        postPready;
   logic [31:0] postPrdata;
   logic [1:0]  postTx;
   logic [1:0]  postRx;
   int          firstReady;

   apb_usrt_slave dut (
      .i_Pclk     (i_Pclk),
      .i_Preset   (i_Preset),
      .i_Psel     (i_Psel),
      .i_Penable  (i_Penable),
      .i_Pwrite   (i_Pwrite),
      .i_Paddr    (i_Paddr),
      .i_Pwdata   (i_Pwdata),
      .o_Prdata   (o_Prdata),
      .o_Pready   (o_Pready),
      .o_Pslverr  (o_Pslverr),
      .o_Tx_Valid (o_Tx_Valid),
      .o_Tx_Data  (o_Tx_Data),
      .i_Tx_Ready (i_Tx_Ready),
      .o_Rx_Req   (o_Rx_Req),
      .i_Rx_Valid (i_Rx_Valid),
      .i_Rx_Data  (i_Rx_Data)
   );

   initial i_Pclk = 1'b0;
   always #5 i_Pclk = ~i_Pclk;

   always @(posedge i_Pclk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_Pclk);
      #1;
   endtask

   // One full APB transfer; lateAt is the tick count after which lateTx/lateRx are driven.
   task automatic applyStimulus(input logic [7:0] addr, input logic write, input logic [31:0] wdata,
                                input logic [1:0] txReady, input logic [1:0] rxValid,
                                input int lateAt, input logic [1:0] lateTx, input logic [1:0] lateRx);
      int n;
      bit got;
      i_Psel     = 1'b1;
      i_Penable  = 1'b0;
      i_Paddr    = addr;
      i_Pwrite   = write;
      i_Pwdata   = wdata;
      i_Tx_Ready = txReady;
      i_Rx_Valid = rxValid;
      txSeen     = '0;
      txCycles   = 0;
      txDataSeen = '0;
      rxSeen     = '0;
      got        = 0;
      tick();
      n = 1;
      i_Penable = 1'b1;
      while (!got && n < 40) begin
         tick();
         n++;
         if (o_Pready) begin
            got            = 1;
            lastLatency    = n;
            lastReadyCycle = cycle;
            lastRdata      = o_Prdata;
            lastSlverr     = o_Pslverr;
         end else begin
            if (o_Tx_Valid != 2'b00) begin
               if (txCycles == 0) txDataSeen = o_Tx_Data;
               txCycles++;
            end
            txSeen = txSeen | o_Tx_Valid;
            rxSeen = rxSeen | o_Rx_Req;
            if (n == lateAt) begin
               i_Tx_Ready = lateTx;
               i_Rx_Valid = lateRx;
            end
         end
      end
      if (!got) begin
         checkOutput("pready_budget", 32'd0, 32'd1);
         lastLatency = -1;
      end
      tick();
      i_Psel     = 1'b0;
      i_Penable  = 1'b0;
      i_Tx_Ready = '0;
      i_Rx_Valid = '0;
      postPready = o_Pready;
      postPrdata = o_Prdata;
      postTx     = o_Tx_Valid;
      postRx     = o_Rx_Req;
   endtask

   initial begin
      i_Preset   = 1'b1;
      i_Psel     = 1'b0;
      i_Penable  = 1'b0;
      i_Pwrite   = 1'b0;
      i_Paddr    = '0;
      i_Pwdata   = '0;
      i_Tx_Ready = '0;
      i_Rx_Valid = '0;
      i_Rx_Data  = {32'hCAFEF00D, 32'h12345678};
      repeat (3) tick();
      i_Preset = 1'b0;
      tick();

      // Reset state
      checkOutput("rst_pready", {31'd0, o_Pready}, 32'd0);
      checkOutput("rst_pslverr", {31'd0, o_Pslverr}, 32'd0);
      checkOutput("rst_prdata", o_Prdata, 32'd0);
      checkOutput("rst_tx_valid", {30'd0, o_Tx_Valid}, 32'd0);
      checkOutput("rst_rx_req", {30'd0, o_Rx_Req}, 32'd0);
      checkOutput("rst_tx_data", o_Tx_Data, 32'd0);

      // TX to channel 1, ready already high
      applyStimulus(8'h04, 1'b1, 32'hDEADBEEF, 2'b10, 2'b00, 0, 2'b00, 2'b00);
      checkOutput("tx1_latency", lastLatency, 32'd3);
      checkOutput("tx1_valid", {30'd0, txSeen}, 32'h2);
      checkOutput("tx1_valid_cycles", txCycles, 32'd1);
      checkOutput("tx1_data", txDataSeen, 32'hDEADBEEF);
      checkOutput("tx1_slverr", {31'd0, lastSlverr}, 32'd0);
      checkOutput("tx1_post_pready", {31'd0, postPready}, 32'd0);
      checkOutput("tx1_post_valid", {30'd0, postTx}, 32'd0);

      // RX from channel 0, valid arrives several cycles into ACCESS
      applyStimulus(8'h00, 1'b0, 32'h0, 2'b00, 2'b00, 7, 2'b00, 2'b01);
      checkOutput("rx0_latency", lastLatency, 32'd8);
      checkOutput("rx0_rdata", lastRdata, 32'h12345678);
      checkOutput("rx0_slverr", {31'd0, lastSlverr}, 32'd0);
      checkOutput("rx0_req", {30'd0, rxSeen}, 32'h1);
      checkOutput("rx0_post_req", {30'd0, postRx}, 32'd0);
      checkOutput("rx0_post_prdata", postPrdata, 32'd0);

      // RX from channel 1, valid already high
      applyStimulus(8'h04, 1'b0, 32'h0, 2'b00, 2'b10, 0, 2'b00, 2'b00);
      checkOutput("rx1_latency", lastLatency, 32'd3);
      checkOutput("rx1_rdata", lastRdata, 32'hCAFEF00D);
      checkOutput("rx1_req", {30'd0, rxSeen}, 32'h2);

      // TX timeout: 16 ACCESS cycles then error
      applyStimulus(8'h04, 1'b1, 32'hA5A5A5A5, 2'b00, 2'b00, 0, 2'b00, 2'b00);
      checkOutput("tmo_latency", lastLatency, 32'd18);
      checkOutput("tmo_slverr", {31'd0, lastSlverr}, 32'd1);
      checkOutput("tmo_rdata", lastRdata, 32'd0);
      checkOutput("tmo_valid_cycles", txCycles, 32'd16);
      checkOutput("tmo_post_valid", {30'd0, postTx}, 32'd0);

      // Handshake in the expiry cycle wins over the timeout
      applyStimulus(8'h04, 1'b1, 32'h0F0F0F0F, 2'b00, 2'b00, 17, 2'b10, 2'b00);
      checkOutput("edge_latency", lastLatency, 32'd18);
      checkOutput("edge_slverr", {31'd0, lastSlverr}, 32'd0);
      checkOutput("edge_valid_cycles", txCycles, 32'd16);

      // Ready on the unaddressed channel is ignored, so channel 0 times out
      applyStimulus(8'h00, 1'b1, 32'h11111111, 2'b10, 2'b00, 0, 2'b00, 2'b00);
      checkOutput("unaddr_latency", lastLatency, 32'd18);
      checkOutput("unaddr_slverr", {31'd0, lastSlverr}, 32'd1);
      checkOutput("unaddr_valid", {30'd0, txSeen}, 32'h1);

      // Status read: tx_ready bit0, rx_valid bit3
      applyStimulus(8'h08, 1'b0, 32'h0, 2'b01, 2'b10, 0, 2'b00, 2'b00);
      checkOutput("status_latency", lastLatency, 32'd2);
      checkOutput("status_rdata", lastRdata, 32'h00000009);
      checkOutput("status_slverr", {31'd0, lastSlverr}, 32'd0);
      checkOutput("status_post_prdata", postPrdata, 32'd0);

      // Write to status and read past the map are errors
      applyStimulus(8'h08, 1'b1, 32'hFFFFFFFF, 2'b11, 2'b11, 0, 2'b00, 2'b00);
      checkOutput("wstatus_latency", lastLatency, 32'd2);
      checkOutput("wstatus_slverr", {31'd0, lastSlverr}, 32'd1);
      checkOutput("wstatus_rdata", lastRdata, 32'd0);
      checkOutput("wstatus_no_tx", {30'd0, txSeen}, 32'd0);
      applyStimulus(8'h0C, 1'b0, 32'h0, 2'b11, 2'b11, 0, 2'b00, 2'b00);
      checkOutput("oob_slverr", {31'd0, lastSlverr}, 32'd1);
      checkOutput("oob_rdata", lastRdata, 32'd0);

      // Reset in the middle of a TX access
      i_Psel     = 1'b1;
      i_Penable  = 1'b0;
      i_Paddr    = 8'h04;
      i_Pwrite   = 1'b1;
      i_Pwdata   = 32'h55AA55AA;
      i_Tx_Ready = 2'b00;
      tick();
      i_Penable = 1'b1;
      tick();
      tick();
      checkOutput("mid_valid_before", {30'd0, o_Tx_Valid}, 32'h2);
      i_Preset = 1'b1;
      tick();
      checkOutput("mid_valid_after", {30'd0, o_Tx_Valid}, 32'd0);
      checkOutput("mid_pready", {31'd0, o_Pready}, 32'd0);
      checkOutput("mid_tx_data", o_Tx_Data, 32'd0);
      i_Preset  = 1'b0;
      i_Psel    = 1'b0;
      i_Penable = 1'b0;
      i_Tx_Ready = 2'b10;
      tick();
      tick();
      checkOutput("mid_no_pready", {31'd0, o_Pready}, 32'd0);
      checkOutput("mid_no_valid", {30'd0, o_Tx_Valid}, 32'd0);
      applyStimulus(8'h04, 1'b1, 32'h600DF00D, 2'b10, 2'b00, 0, 2'b00, 2'b00);
      checkOutput("after_rst_latency", lastLatency, 32'd3);
      checkOutput("after_rst_data", txDataSeen, 32'h600DF00D);
      checkOutput("after_rst_slverr", {31'd0, lastSlverr}, 32'd0);

      // Back-to-back writes to channels 0 and 1
      applyStimulus(8'h00, 1'b1, 32'h01020304, 2'b01, 2'b00, 0, 2'b00, 2'b00);
      firstReady = lastReadyCycle;
      checkOutput("b2b0_data", txDataSeen, 32'h01020304);
      checkOutput("b2b0_valid", {30'd0, txSeen}, 32'h1);
      applyStimulus(8'h04, 1'b1, 32'h05060708, 2'b10, 2'b00, 0, 2'b00, 2'b00);
      checkOutput("b2b_gap", lastReadyCycle - firstReady, 32'd4);
      checkOutput("b2b1_data", txDataSeen, 32'h05060708);
      checkOutput("b2b1_valid", {30'd0, txSeen}, 32'h2);
      checkOutput("b2b1_slverr", {31'd0, lastSlverr}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/apb_usrt_slave.md
APB_USRT_SLAVE -- requirements
Module: apb_usrt_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of i_Paddr.
REQ-002 SHALL have parameter DATA_W, default 32: APB data width and channel data width.
REQ-003 SHALL have parameter N_CH, default 2: number of USRT channels, 1..8, with 2*N_CH <= DATA_W.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum ACCESS-state cycles before an error response, >= 2.
REQ-005 i_Pclk  in  1  single clock; all logic on its rising edge.
REQ-006 i_Preset  in  1  reset, synchronous, active-high.
REQ-007 i_Psel, i_Penable, i_Pwrite  in  1 each  APB select, enable, write.
REQ-008 i_Paddr  in  ADDR_W  byte address; word index W = i_Paddr[ADDR_W-1:2]; bits [1:0] ignored.
REQ-009 i_Pwdata  in  DATA_W  write data.
REQ-010 o_Prdata  out  DATA_W; o_Pready  out  1; o_Pslverr  out  1; all registered.
REQ-011 o_Tx_Valid  out  N_CH; o_Tx_Data  out  DATA_W, shared by all channels; i_Tx_Ready  in  N_CH.
REQ-012 o_Rx_Req  out  N_CH; i_Rx_Valid  in  N_CH; i_Rx_Data  in  N_CH*DATA_W, channel k at [k*DATA_W +: DATA_W].

Function
REQ-013 Address map:
- W < N_CH: data register of channel W; write = TX, read = RX.
- W == N_CH: read-only status, bit k = i_Tx_Ready[k], bit N_CH+k = i_Rx_Valid[k], other bits 0.
- Any other W, or a write to the status register: error.
REQ-014 FSM states: s_IDLE, s_SETUP, s_ACCESS, s_RESP.
REQ-015 s_IDLE: on i_Psel=1 and i_Penable=0, latch address, write, wdata and decode result, then go to s_SETUP.
REQ-016 s_SETUP: i_Psel=0 goes to s_IDLE; i_Penable=0 stays; i_Penable=1 goes to s_ACCESS for a data register, otherwise to s_RESP.
REQ-017 s_SETUP to s_RESP for status: o_Prdata loads the status sampled that cycle, o_Pslverr=0.
REQ-018 s_SETUP to s_RESP for error: o_Pslverr=1, o_Prdata=0.
REQ-019 s_ACCESS, TX: o_Tx_Valid[k]=1 and o_Tx_Data=latched wdata; the handshake completes in the cycle i_Tx_Ready[k]=1; next state s_RESP with o_Pslverr=0.
REQ-020 s_ACCESS, RX: o_Rx_Req[k]=1; completes in the cycle i_Rx_Valid[k]=1; o_Prdata captures channel k data; next state s_RESP.
REQ-021 o_Tx_Valid and o_Rx_Req SHALL be one-hot or zero, asserted only in s_ACCESS, and dropped the cycle after the handshake.
REQ-022 Wait counter: cleared on entering s_ACCESS, +1 per s_ACCESS cycle; at TIMEOUT-1 with no handshake, go to s_RESP with o_Pslverr=1, o_Prdata=0, strobe dropped.
REQ-023 A handshake in the timeout cycle SHALL win (no error).
REQ-024 s_RESP: o_Pready=1 for exactly one cycle, then s_IDLE; o_Prdata and o_Pslverr are 0 outside s_RESP.
REQ-025 Minimum latency: status/error transfer = setup cycle + 1 access cycle + RESP; data transfer with ready/valid already high adds exactly 1 cycle.
REQ-026 Back-to-back: a setup phase presented in the cycle after s_RESP SHALL be accepted by s_IDLE with no idle gap.
REQ-027 i_Tx_Ready/i_Rx_Valid of unaddressed channels SHALL be ignored except in status reads.

Reset
REQ-028 Reset (including mid-transfer): state s_IDLE; all outputs, counter and latches 0; any pending strobe drops on the next edge with no completion.

Structure
REQ-029 Package apb_usrt_pkg SHALL hold the state enum, parameter defaults and a status-index helper (returns N_CH).
REQ-030 Sub-module apb_wait_timer SHALL hold the clear/increment/expire counter (TIMEOUT param, expire output); no other sub-modules.

Verification
REQ-031 Write 0xDEADBEEF to 0x04, i_Tx_Ready[1]=1 -> o_Tx_Valid=2'b10 one cycle, o_Tx_Data=0xDEADBEEF, o_Pready 3 cycles after setup, o_Pslverr=0.
REQ-032 Read 0x00, i_Rx_Valid[0] rises 5 cycles into ACCESS with data 0x12345678 -> o_Prdata=0x12345678 with o_Pready, o_Pslverr=0.
REQ-033 Write 0x04, i_Tx_Ready=0 forever, TIMEOUT=16 -> o_Pready and o_Pslverr=1 after 16 ACCESS cycles, o_Tx_Valid=0 afterwards.
REQ-034 Read 0x08 (status), i_Tx_Ready=2'b01, i_Rx_Valid=2'b10 -> o_Prdata=0x00000009; write 0x08 or read 0x0C -> o_Pslverr=1, o_Prdata=0.
REQ-035 i_Preset during ACCESS of a TX -> o_Tx_Valid=0 next cycle, no o_Pready, the next transfer completes normally.
REQ-036 Two back-to-back writes to channels 0 and 1, both ready -> two o_Pready pulses 4 cycles apart, correct data on each.
